// File: rtl/exception_controller_if.sv
// Pipeline <-> exception controller signal bundle: detect-stage flags in,
// redirect/squash controls and captured exception state out.
interface exception_controller_if;
    logic        exc_req;
    logic        addr_err;
    logic        div0;
    logic        ovf;
    logic [31:0] alu_out;
    logic [31:0] pc_in;
    logic        eret;
    logic        flush;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic [31:0] badvaddr;
    logic        in_handler;
    logic        double_fault;
    logic [7:0]  exc_count;

    modport master (
        output exc_req, addr_err, div0, ovf, alu_out, pc_in, eret,
        input  flush, stall, pc_sel, pc_target, epc, cause, badvaddr,
               in_handler, double_fault, exc_count
    );

    modport slave (
        input  exc_req, addr_err, div0, ovf, alu_out, pc_in, eret,
        output flush, stall, pc_sel, pc_target, epc, cause, badvaddr,
               in_handler, double_fault, exc_count
    );
endinterface

// File: rtl/exception_controller.sv
// Exception sequencer: captures EPC/cause/badvaddr, squashes the pipeline,
// vectors to the handler and returns to EPC+4 on eret.
module exception_controller #(
    parameter logic [31:0] HANDLER_VEC  = 32'h0000_0180,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst,
    exception_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FLUSH, VECTOR, HANDLER, RETURN} state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic        flush_r;
    logic        stall_r;
    logic        pc_sel_r;
    logic [31:0] pc_target_r;
    logic [31:0] epc_r;
    logic [3:0]  cause_r;
    logic [31:0] badvaddr_r;
    logic        in_handler_r;
    logic        double_fault_r;
    logic [7:0]  exc_count_r;

    // Address error outranks divide-by-zero, which outranks overflow.
    function automatic logic [3:0] cause_code(input logic ae, input logic d0, input logic ov);
        if (ae)      return 4'h4;
        else if (d0) return 4'h9;
        else if (ov) return 4'hC;
        else         return 4'hF;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flush_cnt      <= 3'd0;
            flush_r        <= 1'b0;
            stall_r        <= 1'b0;
            pc_sel_r       <= 1'b0;
            pc_target_r    <= 32'd0;
            epc_r          <= 32'd0;
            cause_r        <= 4'd0;
            badvaddr_r     <= 32'd0;
            in_handler_r   <= 1'b0;
            double_fault_r <= 1'b0;
            exc_count_r    <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.exc_req) begin
                        state       <= FLUSH;
                        flush_cnt   <= 3'd1;
                        flush_r     <= 1'b1;
                        stall_r     <= 1'b1;
                        epc_r       <= bus.pc_in;
                        cause_r     <= cause_code(bus.addr_err, bus.div0, bus.ovf);
                        badvaddr_r  <= bus.addr_err ? bus.alu_out : 32'd0;
                        exc_count_r <= sat_inc(exc_count_r);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state       <= VECTOR;
                        flush_cnt   <= 3'd0;
                        flush_r     <= 1'b0;
                        pc_sel_r    <= 1'b1;
                        pc_target_r <= HANDLER_VEC;
                    end else begin
                        flush_cnt <= flush_cnt + 3'd1;
                    end
                end
                VECTOR: begin
                    state        <= HANDLER;
                    stall_r      <= 1'b0;
                    pc_sel_r     <= 1'b0;
                    pc_target_r  <= 32'd0;
                    in_handler_r <= 1'b1;
                end
                HANDLER: begin
                    // A nested exception is only recorded; the captured state stays intact.
                    if (bus.exc_req) double_fault_r <= 1'b1;
                    if (bus.eret) begin
                        state        <= RETURN;
                        in_handler_r <= 1'b0;
                        pc_sel_r     <= 1'b1;
                        pc_target_r  <= epc_r + 32'd4;
                        flush_r      <= 1'b1;
                    end
                end
                RETURN: begin
                    state       <= IDLE;
                    pc_sel_r    <= 1'b0;
                    pc_target_r <= 32'd0;
                    flush_r     <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    flush_cnt   <= 3'd0;
                    flush_r     <= 1'b0;
                    stall_r     <= 1'b0;
                    pc_sel_r    <= 1'b0;
                    pc_target_r <= 32'd0;
                    in_handler_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush        = flush_r;
    assign bus.stall        = stall_r;
    assign bus.pc_sel       = pc_sel_r;
    assign bus.pc_target    = pc_target_r;
    assign bus.epc          = epc_r;
    assign bus.cause        = cause_r;
    assign bus.badvaddr     = badvaddr_r;
    assign bus.in_handler   = in_handler_r;
    assign bus.double_fault = double_fault_r;
    assign bus.exc_count    = exc_count_r;
endmodule

// File: tb/tb_exception_controller.sv
// Directed, table-driven bench for exception_controller (default parameters).
module tb_exception_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exception_controller_if bus();

    exception_controller #(
        .HANDLER_VEC (32'h0000_0180),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst, exc, ae, d0, ov;
        logic [31:0] alu, pc;
        logic        eret;
        logic        e_flush, e_stall, e_sel;
        logic [31:0] e_tgt, e_epc;
        logic [3:0]  e_cause;
        logic [31:0] e_bad;
        logic        e_inh, e_df;
        logic [7:0]  e_cnt;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic x, input logic ae, input logic d0, input logic ov,
        input logic [31:0] alu, input logic [31:0] pc, input logic er,
        input logic fl, input logic st, input logic sel, input logic [31:0] tgt,
        input logic [31:0] epc, input logic [3:0] cause, input logic [31:0] bad,
        input logic inh, input logic df, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.exc = x; v.ae = ae; v.d0 = d0; v.ov = ov;
        v.alu = alu; v.pc = pc; v.eret = er;
        v.e_flush = fl; v.e_stall = st; v.e_sel = sel; v.e_tgt = tgt;
        v.e_epc = epc; v.e_cause = cause; v.e_bad = bad;
        v.e_inh = inh; v.e_df = df; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample on the falling edge.
    task automatic apply(input logic r, input logic x, input logic ae, input logic d0,
                         input logic ov, input logic [31:0] alu, input logic [31:0] pc,
                         input logic er);
        rst = r; bus.exc_req = x; bus.addr_err = ae; bus.div0 = d0; bus.ovf = ov;
        bus.alu_out = alu; bus.pc_in = pc; bus.eret = er;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // rst exc ae d0 ov alu pc eret | flush stall sel tgt epc cause bad inh df cnt
        vecs.push_back(mk(1,0,0,0,0, 0,        0,        0, 0,0,0, 0,      0,      0,    0,      0,0, 0));
        vecs.push_back(mk(0,1,0,0,1, 0,        32'h40,   0, 1,1,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,1,0,0,1, 0,        32'h99,   0, 1,1,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,1,1, 32'h180,32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        1, 0,0,0, 0,      32'h40, 4'hC, 0,      1,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,0,0, 0,      32'h40, 4'hC, 0,      1,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        1, 1,0,1, 32'h44, 32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        1, 0,0,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        1, 0,0,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,1,1,1,0, 32'h1002, 32'h200,  0, 1,1,0, 0,      32'h200,4'h4, 32'h1002,0,0, 2));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 1,1,0, 0,      32'h200,4'h4, 32'h1002,0,0, 2));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,1,1, 32'h180,32'h200,4'h4, 32'h1002,0,0, 2));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,0,0, 0,      32'h200,4'h4, 32'h1002,1,0, 2));
        vecs.push_back(mk(0,1,0,0,1, 32'h9,    32'h300,  1, 1,0,1, 32'h204,32'h200,4'h4, 32'h1002,0,1, 2));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,0,0, 0,      32'h200,4'h4, 32'h1002,0,1, 2));
        vecs.push_back(mk(0,1,0,1,0, 32'h77,   32'h500,  0, 1,1,0, 0,      32'h500,4'h9, 0,      0,1, 3));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 1,1,0, 0,      32'h500,4'h9, 0,      0,1, 3));
        vecs.push_back(mk(1,0,0,0,0, 0,        0,        0, 0,0,0, 0,      0,      0,    0,      0,0, 0));
        vecs.push_back(mk(0,1,0,0,1, 0,        32'h40,   0, 1,1,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 1,1,0, 0,      32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,1,1, 32'h180,32'h40, 4'hC, 0,      0,0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,        0,        0, 0,0,0, 0,      32'h40, 4'hC, 0,      1,0, 1));
        vecs.push_back(mk(0,1,1,0,0, 32'h55,   32'h66,   0, 0,0,0, 0,      32'h40, 4'hC, 0,      1,1, 1));
        vecs.push_back(mk(1,1,0,0,1, 0,        32'h40,   1, 0,0,0, 0,      0,      0,    0,      0,0, 0));
        vecs.push_back(mk(0,1,0,0,0, 32'h33,   32'h8,    0, 1,1,0, 0,      32'h8,  4'hF, 0,      0,0, 1));

        rst = 1'b1;
        bus.exc_req = 0; bus.addr_err = 0; bus.div0 = 0; bus.ovf = 0;
        bus.alu_out = 0; bus.pc_in = 0; bus.eret = 0;
        @(negedge clk);

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v = vecs[i];
            apply(v.rst, v.exc, v.ae, v.d0, v.ov, v.alu, v.pc, v.eret);
            tag = $sformatf("v%0d", i);
            chk({tag, ".flush"},        32'(bus.flush),        32'(v.e_flush));
            chk({tag, ".stall"},        32'(bus.stall),        32'(v.e_stall));
            chk({tag, ".pc_sel"},       32'(bus.pc_sel),       32'(v.e_sel));
            chk({tag, ".pc_target"},    bus.pc_target,         v.e_tgt);
            chk({tag, ".epc"},          bus.epc,               v.e_epc);
            chk({tag, ".cause"},        32'(bus.cause),        32'(v.e_cause));
            chk({tag, ".badvaddr"},     bus.badvaddr,          v.e_bad);
            chk({tag, ".in_handler"},   32'(bus.in_handler),   32'(v.e_inh));
            chk({tag, ".double_fault"}, 32'(bus.double_fault), 32'(v.e_df));
            chk({tag, ".exc_count"},    32'(bus.exc_count),    32'(v.e_cnt));
        end

        // 256 exception/eret round trips from the top of the address space.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            int exp_cnt;
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            apply(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            apply(0, 0, 0, 0, 0, 0, 0, 1);
            if (i == 0 || i == 255) begin
                chk($sformatf("wrap%0d.pc_sel", i),    32'(bus.pc_sel), 32'd1);
                chk($sformatf("wrap%0d.pc_target", i), bus.pc_target,   32'd0);
            end
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("sat%0d.exc_count", i), 32'(bus.exc_count), 32'(exp_cnt));
        end
        chk("sat.epc", bus.epc, 32'hFFFF_FFFC);
        chk("sat.in_handler", 32'(bus.in_handler), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
